// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, one bit per clock).
// Digits and overflow flag are registered and only update on the completion edge.
module bin_to_bcd_seq #(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [3:0]      thousands,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones
);

  localparam int BCD_W  = 16;
  localparam int WORK_W = BCD_W + IN_W;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t              r_state;
  logic [WORK_W-1:0]   r_work;
  logic [3:0]          r_cnt;
  logic                r_ovf_pending;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [BCD_W-1:0]    r_digits;

  logic [WORK_W-1:0]   w_corr;
  logic [WORK_W-1:0]   w_shift;
  logic                w_ovf_in;
  logic [IN_W-1:0]     w_bin_sat;

  assign w_ovf_in  = (bin > IN_W'(MAX_VAL));
  assign w_bin_sat = w_ovf_in ? IN_W'(MAX_VAL) : bin;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_corr unassigned (no latch).
    w_corr = r_work;
    for (int i = 0; i < 4; i++) begin
      if (r_work[IN_W+4*i +: 4] >= 4'd5) begin
        w_corr[IN_W+4*i +: 4] = r_work[IN_W+4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_shift = w_corr << 1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_work        <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ovf         <= 1'b0;
      r_digits      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state       <= CONV;
            r_busy        <= 1'b1;
            r_work        <= {{BCD_W{1'b0}}, w_bin_sat};
            r_cnt         <= '0;
            r_ovf_pending <= w_ovf_in;
          end
        end
        CONV: begin
          r_work <= w_shift;
          r_cnt  <= r_cnt + 4'd1;
          if (r_cnt == 4'(IN_W - 1)) begin
            r_digits <= w_shift[WORK_W-1:IN_W];
            r_ovf    <= r_ovf_pending;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign thousands = r_digits[15:12];
  assign hundreds  = r_digits[11:8];
  assign tens      = r_digits[7:4];
  assign ones      = r_digits[3:0];

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that feeds the four-digit seven-segment multiplexer. It accepts a 14-bit unsigned binary value on a start strobe and runs the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents registered thousands/hundreds/tens/ones digits that hold steady for the display stage until the next conversion completes. Values above 9999 saturate to 9999 and raise an overflow flag.

## Interface
- IN_W, 14: binary input width. Fixed at 14 for the 4-digit display; other values are unsupported.
- MAX_VAL, 9999: saturation limit; it equals the largest 4-digit BCD value.
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  conversion request; sampled only in IDLE
- bin  input  14  unsigned binary value; captured on the accepted start edge
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when new digits are valid
- ovf  output  1  registered with the digits; high if the captured bin exceeded MAX_VAL
- thousands  output  4  BCD digit 3
- hundreds  output  4  BCD digit 2
- tens  output  4  BCD digit 1
- ones  output  4  BCD digit 0

## Operation
- States:
  - IDLE: waiting for start.
  - CONV: iterating.
- IDLE → CONV when start=1 at a rising edge. That edge performs the following:
  - If bin > 9999, load 9999 into the binary field and set ovf_pending=1. Otherwise load bin and set ovf_pending=0.
  - Clear the 16-bit BCD field.
  - Clear the iteration counter (4 bits).
- Working register is 30 bits: {bcd[15:0], bin[13:0]}.
- CONV, each edge:
  - For each of the 4 BCD nibbles, if nibble ≥ 5, add 3. The correction is computed combinationally on the current register value.
  - Then shift the whole corrected register left by 1.
  - Increment the counter.
- CONV, on the edge that performs iteration 14 (counter==13):
  - Write the shifted BCD result to thousands/hundreds/tens/ones.
  - Copy ovf_pending to ovf.
  - Assert done for the following cycle.
  - Return to IDLE.
- Corrected nibbles never exceed 4 bits: inputs are at most 9, so the largest corrected value is 9+3=12.
- start while in CONV is ignored. It does not restart the conversion or alter the captured input.
- Output digits and ovf change only on the completion edge. Between completions they hold their last values, including during CONV, so the display never shows partial results.
- Reset (async, any state, including mid-conversion):
  - State becomes IDLE; counter and working register are cleared.
  - busy=0, done=0, ovf=0, all digits=0.
  - No done pulse is produced for the aborted conversion.

## Timing
- Start accepted at edge E0. busy=1 after E0.
- Iterations occur at E1..E14.
- After E14: digits and ovf valid, done=1, busy=0.
- After E15: done=0.
- Latency from the start edge to valid digits is 14 cycles.
- done is high for exactly one cycle per completed conversion.
- The block is in IDLE during the done cycle. A start held high then is accepted at E15, giving back-to-back throughput of one conversion per 15 cycles.
- busy is the state decode (CONV) and is registered. busy and done are never high in the same cycle.
- The bin input need not be held after the accepted start edge.
- No combinational path from inputs to outputs.

## Test plan
- Reset values: assert rst_n=0 mid-simulation → all outputs 0 immediately (async), before the next clk edge.
- Basic conversion: bin=1234, start pulsed one cycle → done exactly 14 cycles after the start edge, with thousands/hundreds/tens/ones = 1/2/3/4, ovf=0, busy high for 14 cycles.
- Boundaries:
  - bin=0 → digits 0/0/0/0.
  - bin=9999 → 9/9/9/9, ovf=0.
  - bin=10000 → 9/9/9/9, ovf=1.
  - bin=16383 → 9/9/9/9, ovf=1.
- Start during CONV: start bin=42, then pulse start with bin=777 at cycle 5 → a single done with digits 0/0/4/2. start held high continuously → done pulses every 15 cycles.
- Reset mid-conversion: start bin=5678, drop rst_n at cycle 7 for 2 cycles → no done, digits 0; a new start with bin=5678 → 5/6/7/8 after 14 cycles.
- Hold behaviour: after converting 8888, start bin=305 → digits stay 8/8/8/8 throughout CONV and switch to 0/3/0/5 only on the done cycle.
